spi_master_stream: RTL and testbench



---
 rtl/spi_pkg.sv | 34 +++
 rtl/spi_half_tick.sv | 30 +++
 rtl/spi_master_stream.sv | 191 +++++++++++++++++++
 tb/tb_spi_master_stream.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the streaming SPI master.
package spi_pkg;

  localparam int unsigned MAX_WIDTH = 32;
  localparam int unsigned IDX_W     = $clog2(MAX_WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_WAIT,
    ST_HOLD,
    ST_GAP
  } spi_state_t;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Reverse the low 'width' bits of value; bits above width return zero.
  function automatic logic [MAX_WIDTH-1:0] bit_reverse(input logic [MAX_WIDTH-1:0] value,
                                                        input int unsigned         width);
    logic [MAX_WIDTH-1:0] result;
    result = '0;
    for (int i = 0; i < int'(MAX_WIDTH); i++) begin
      if (i < int'(width)) begin
        result[IDX_W'(i)] = value[IDX_W'(int'(width) - 1 - i)];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/spi_half_tick.sv
// SCLK half-period divider: fires tick_c every CLK_DIV enabled cycles.
module spi_half_tick
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned      CNT_W   = cnt_width(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick_c = en && (cnt == CNT_MAX);

  // Count while enabled; restart on each tick and on every state change.
  always_ff @(posedge clk) begin
    if (rst || clr || tick_c) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_master_stream.sv
// Streaming SPI master: any CPOL/CPHA, word width and divider; cs_n framed by tx_last.
module spi_master_stream
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_DIV    = 2,
  parameter bit          CPOL       = 1'b0,
  parameter bit          CPHA       = 1'b0,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_dc,
  input  logic                  tx_last,
  output logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  busy,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  mosi,
  output logic                  dc,
  input  logic                  miso
);

  localparam int unsigned       EDGE_W    = cnt_width(2 * DATA_WIDTH);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_WIDTH - 1);

  typedef logic [DATA_WIDTH-1:0] word_t;

  // Map between wire order and the LSB-out/LSB-in shifters.
  function automatic word_t orient(input word_t w);
    return MSB_FIRST ? DATA_WIDTH'(bit_reverse(MAX_WIDTH'(w), DATA_WIDTH)) : w;
  endfunction

  spi_state_t        state_q, state_d;
  word_t             tx_shift, tx_shift_d;
  word_t             rx_shift, rx_shift_d;
  word_t             rx_data_d;
  word_t             tx_next, rx_next, load_c;
  logic [EDGE_W-1:0] edge_cnt, edge_d;
  logic              last_q, last_d;
  logic              sclk_d, cs_n_d, mosi_d, dc_d, rx_valid_d;
  logic              sample_c;
  logic              tick_c, div_en_c, div_clr_c;

  assign tx_ready  = ((state_q == ST_IDLE) || (state_q == ST_WAIT)) && !rst;
  assign busy      = (state_q != ST_IDLE);
  assign div_en_c  = (state_q == ST_SETUP) || (state_q == ST_SHIFT) ||
                     (state_q == ST_HOLD)  || (state_q == ST_GAP);
  assign div_clr_c = (state_d != state_q);

  spi_half_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_half_tick (
    .clk    (clk),
    .rst    (rst),
    .en     (div_en_c),
    .clr    (div_clr_c),
    .tick_c (tick_c)
  );

  // Next-state and next-register values for the whole datapath.
  always_comb begin
    state_d    = state_q;
    sclk_d     = sclk;
    cs_n_d     = cs_n;
    mosi_d     = mosi;
    dc_d       = dc;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data;
    tx_shift_d = tx_shift;
    rx_shift_d = rx_shift;
    last_d     = last_q;
    edge_d     = edge_cnt;
    tx_next    = tx_shift >> 1;
    rx_next    = rx_shift >> 1;
    rx_next[DATA_WIDTH-1] = miso;
    load_c     = orient(tx_data);
    // Even edge count is the leading edge; CPHA picks which edge samples.
    sample_c   = CPHA ? edge_cnt[0] : ~edge_cnt[0];

    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          tx_shift_d = load_c;
          mosi_d     = load_c[0];
          dc_d       = tx_dc;
          last_d     = tx_last;
          cs_n_d     = 1'b0;
          edge_d     = '0;
          state_d    = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (tick_c) begin
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (tick_c) begin
          sclk_d = ~sclk;
          edge_d = edge_cnt + EDGE_W'(1);
          if (sample_c) begin
            rx_shift_d = rx_next;
          end else if (edge_cnt != LAST_EDGE) begin
            // CPHA=1 re-presents the current bit; CPHA=0 advances to the next one.
            mosi_d     = CPHA ? tx_shift[0] : tx_next[0];
            tx_shift_d = tx_next;
          end
          if (edge_cnt == LAST_EDGE) begin
            edge_d     = '0;
            rx_valid_d = 1'b1;
            rx_data_d  = orient(rx_shift_d);
            state_d    = last_q ? ST_HOLD : ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (tx_valid) begin
          tx_shift_d = load_c;
          mosi_d     = load_c[0];
          dc_d       = tx_dc;
          last_d     = tx_last;
          edge_d     = '0;
          state_d    = ST_SHIFT;
        end
      end

      ST_HOLD: begin
        if (tick_c) begin
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          state_d = ST_GAP;
        end
      end

      ST_GAP: begin
        if (tick_c) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pads, shifters and received word; a reset discards any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk     <= CPOL;
      cs_n     <= 1'b1;
      mosi     <= 1'b0;
      dc       <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      last_q   <= 1'b0;
      edge_cnt <= '0;
    end else begin
      sclk     <= sclk_d;
      cs_n     <= cs_n_d;
      mosi     <= mosi_d;
      dc       <= dc_d;
      rx_valid <= rx_valid_d;
      rx_data  <= rx_data_d;
      tx_shift <= tx_shift_d;
      rx_shift <= rx_shift_d;
      last_q   <= last_d;
      edge_cnt <= edge_d;
    end
  end

endmodule

// File: tb/tb_spi_master_stream.sv
// Scoreboard bench: mode 0 / 8-bit / div 2 MSB-first and mode 3 / 16-bit / div 1 LSB-first, MISO looped to MOSI.
module tb_spi_master_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Instance 0: mode 0, W=8, CLK_DIV=2, MSB first.
  logic       tx_valid0, tx_ready0, tx_dc0, tx_last0, rx_valid0, busy0;
  logic       sclk0, cs_n0, mosi0, dc0, miso0;
  logic [7:0] tx_data0, rx_data0;
  assign miso0 = mosi0;

  spi_master_stream #(
    .DATA_WIDTH (8), .CLK_DIV (2), .CPOL (1'b0), .CPHA (1'b0), .MSB_FIRST (1'b1)
  ) u_dut0 (
    .clk (clk), .rst (rst),
    .tx_valid (tx_valid0), .tx_ready (tx_ready0), .tx_data (tx_data0),
    .tx_dc (tx_dc0), .tx_last (tx_last0),
    .rx_valid (rx_valid0), .rx_data (rx_data0), .busy (busy0),
    .sclk (sclk0), .cs_n (cs_n0), .mosi (mosi0), .dc (dc0), .miso (miso0)
  );

  // Instance 1: mode 3, W=16, CLK_DIV=1, LSB first.
  logic        tx_valid1, tx_ready1, tx_dc1, tx_last1, rx_valid1, busy1;
  logic        sclk1, cs_n1, mosi1, dc1, miso1;
  logic [15:0] tx_data1, rx_data1;
  assign miso1 = mosi1;

  spi_master_stream #(
    .DATA_WIDTH (16), .CLK_DIV (1), .CPOL (1'b1), .CPHA (1'b1), .MSB_FIRST (1'b0)
  ) u_dut1 (
    .clk (clk), .rst (rst),
    .tx_valid (tx_valid1), .tx_ready (tx_ready1), .tx_data (tx_data1),
    .tx_dc (tx_dc1), .tx_last (tx_last1),
    .rx_valid (rx_valid1), .rx_data (rx_data1), .busy (busy1),
    .sclk (sclk1), .cs_n (cs_n1), .mosi (mosi1), .dc (dc1), .miso (miso1)
  );

  logic [31:0] q0[$];
  logic [31:0] q1[$];

  // Slave model 0: sample MOSI on rising SCLK (mode 0), MSB first.
  logic [7:0]  mon0;
  int          bits0;
  logic        sclk0_prev, rxv0_prev;
  logic [31:0] exp0;
  always @(negedge clk) begin
    if (rst) begin
      bits0 = 0; sclk0_prev = 1'b0; rxv0_prev = 1'b0;
    end else begin
      if (sclk0 && !sclk0_prev && !cs_n0) begin
        mon0 = {mon0[6:0], mosi0};
        bits0++;
      end
      if (rx_valid0) begin
        check("rxv0_pulse", 32'(rxv0_prev), 0);
        if (q0.size() == 0) begin
          check("sb0_empty", 32'(q0.size()), 1);
        end else begin
          exp0 = q0.pop_front();
          check("rx0_data", 32'(rx_data0), exp0);
          check("mosi0_word", 32'(mon0), exp0);
          check("sclk0_pulses", 32'(bits0), 8);
        end
        bits0 = 0;
      end
      sclk0_prev = sclk0;
      rxv0_prev  = rx_valid0;
    end
  end

  // Slave model 1: sample MOSI on rising SCLK (trailing edge in mode 3), LSB first.
  logic [15:0] mon1;
  int          bits1;
  logic        sclk1_prev, rxv1_prev;
  logic [31:0] exp1;
  always @(negedge clk) begin
    if (rst) begin
      bits1 = 0; sclk1_prev = 1'b1; rxv1_prev = 1'b0;
    end else begin
      if (sclk1 && !sclk1_prev && !cs_n1) begin
        mon1 = {mosi1, mon1[15:1]};
        bits1++;
      end
      if (rx_valid1) begin
        check("rxv1_pulse", 32'(rxv1_prev), 0);
        if (q1.size() == 0) begin
          check("sb1_empty", 32'(q1.size()), 1);
        end else begin
          exp1 = q1.pop_front();
          check("rx1_data", 32'(rx_data1), exp1);
          check("mosi1_word", 32'(mon1), exp1);
          check("sclk1_pulses", 32'(bits1), 16);
        end
        bits1 = 0;
      end
      sclk1_prev = sclk1;
      rxv1_prev  = rx_valid1;
    end
  end

  // Offer one word; returns just after the accepting edge.
  task automatic send0(input logic [7:0] d, input logic dcv, input logic last, input bit keep);
    int n;
    n = 0;
    tx_data0 = d; tx_dc0 = dcv; tx_last0 = last; tx_valid0 = 1'b1;
    while (!tx_ready0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready0) check("ready0_timeout", 32'(tx_ready0), 1);
    else q0.push_back(32'(d));
    @(posedge clk);
    #1;
    if (!keep) tx_valid0 = 1'b0;
  endtask

  task automatic send1(input logic [15:0] d, input logic dcv, input logic last, input bit keep);
    int n;
    n = 0;
    tx_data1 = d; tx_dc1 = dcv; tx_last1 = last; tx_valid1 = 1'b1;
    while (!tx_ready1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready1) check("ready1_timeout", 32'(tx_ready1), 1);
    else q1.push_back(32'(d));
    @(posedge clk);
    #1;
    if (!keep) tx_valid1 = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   n, cs_cnt, busy_cnt, run, max_run, bad, edges;
    logic m, d, p, last;

    rst = 1'b1;
    tx_valid0 = 1'b0; tx_data0 = '0; tx_dc0 = 1'b0; tx_last0 = 1'b0;
    tx_valid1 = 1'b0; tx_data1 = '0; tx_dc1 = 1'b0; tx_last1 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_sclk0",  32'(sclk0), 0);
    check("rst_cs_n0",  32'(cs_n0), 1);
    check("rst_mosi0",  32'(mosi0), 0);
    check("rst_dc0",    32'(dc0), 0);
    check("rst_rxv0",   32'(rx_valid0), 0);
    check("rst_rxd0",   32'(rx_data0), 0);
    check("rst_busy0",  32'(busy0), 0);
    check("rst_ready0", 32'(tx_ready0), 0);
    check("rst_sclk1",  32'(sclk1), 1);
    check("rst_cs_n1",  32'(cs_n1), 1);
    rst = 1'b0;
    @(negedge clk);
    check("ready0_after_rst", 32'(tx_ready0), 1);
    check("ready1_after_rst", 32'(tx_ready1), 1);

    // Mode 0 single word 0xA5: frame length and ready latency
    send0(8'hA5, 1'b0, 1'b1, 1'b0);
    n = 0; cs_cnt = 0; busy_cnt = 0;
    do begin
      @(negedge clk);
      n++;
      if (!cs_n0) cs_cnt++;
      if (busy0) busy_cnt++;
    end while (!tx_ready0 && n < 500);
    check("t1_ready_lat", 32'(n), 39);
    check("t1_cs_low", 32'(cs_cnt), 36);
    check("t1_busy", 32'(busy_cnt), 38);

    // Stall in WAIT, then resume without SETUP; dc follows word1
    send0(8'h3C, 1'b0, 1'b0, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_ready0 && n < 500);
    check("t2_wait_lat", 32'(n), 35);
    m = mosi0; d = dc0;
    check("t2_dc_w0", 32'(dc0), 0);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (cs_n0 !== 1'b0 || sclk0 !== 1'b0 || mosi0 !== m || dc0 !== d || tx_ready0 !== 1'b1) bad++;
    end
    check("t2_stall_hold", 32'(bad), 0);
    send0(8'hDA, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    n = 1;
    check("t2_dc_w1", 32'(dc0), 1);
    check("t2_first_bit", 32'(mosi0), 1);
    while (sclk0 == 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t2_resume_lat", 32'(n), 3);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_ready0 && n < 500);
    check("t2_dc_after_gap", 32'(dc0), 1);
    check("t2_cs_idle", 32'(cs_n0), 1);

    // Reset after five SCLK edges: partial word discarded
    send0(8'h96, 1'b1, 1'b1, 1'b0);
    edges = 0; n = 0; p = sclk0;
    while (edges < 5 && n < 200) begin
      @(negedge clk);
      n++;
      if (sclk0 !== p) begin
        edges++;
        p = sclk0;
      end
    end
    check("t3_edges", 32'(edges), 5);
    rst = 1'b1;
    @(negedge clk);
    q0.delete();
    check("t3_cs_n", 32'(cs_n0), 1);
    check("t3_sclk", 32'(sclk0), 0);
    check("t3_mosi", 32'(mosi0), 0);
    check("t3_dc", 32'(dc0), 0);
    check("t3_rxv", 32'(rx_valid0), 0);
    check("t3_rxd", 32'(rx_data0), 0);
    check("t3_busy", 32'(busy0), 0);
    check("t3_ready_in_rst", 32'(tx_ready0), 0);
    rst = 1'b0;
    @(negedge clk);
    check("t3_ready_after", 32'(tx_ready0), 1);
    repeat (40) @(negedge clk);

    // Mode 3 LSB-first single word 0x1234
    send1(16'h1234, 1'b0, 1'b1, 1'b0);
    n = 0; cs_cnt = 0;
    do begin
      @(negedge clk);
      n++;
      if (!cs_n1) cs_cnt++;
    end while (!tx_ready1 && n < 500);
    check("t4_ready_lat", 32'(n), 36);
    check("t4_cs_low", 32'(cs_cnt), 34);

    // Mode 3 burst with tx_valid held: one frame, one-cycle WAIT
    fork
      begin
        send1(16'h0001, 1'b0, 1'b0, 1'b1);
        send1(16'h8000, 1'b1, 1'b0, 1'b1);
        send1(16'hFFFF, 1'b0, 1'b0, 1'b1);
        send1(16'h1234, 1'b1, 1'b1, 1'b0);
      end
      begin
        cs_cnt = 0; run = 0; max_run = 0; n = 0;
        while (cs_n1 && n < 100) begin
          @(negedge clk);
          n++;
        end
        while (!cs_n1 && n < 1000) begin
          if (sclk1) run++;
          else run = 0;
          if (run > max_run) max_run = run;
          cs_cnt++;
          @(negedge clk);
          n++;
        end
      end
    join
    check("t5_cs_low", 32'(cs_cnt), 133);
    check("t5_idle_run", 32'(max_run), 2);

    // Random words with random framing and gaps
    for (int i = 0; i < 8; i++) begin
      last = (i == 7) || ($urandom_range(0, 3) == 0);
      send1(16'($urandom), 1'($urandom_range(0, 1)), last, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    n = 0;
    while ((busy0 || busy1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check("idle_busy1", 32'(busy1), 0);
    check("sb0_left", 32'(q0.size()), 0);
    check("sb1_left", 32'(q1.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
